// File: rtl/calc_sequencer.sv
// Keypad calculator sequencer: accumulates decimal operands, latches operators and
// drives a handshake to an external ALU, with chain mode, timeout and error recovery.
module calc_sequencer #(
  parameter int unsigned MAX_DIGITS = 8,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        alu_start,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [1:0]  alu_op,
  input  logic        alu_done,
  input  logic [31:0] alu_result,
  input  logic        alu_err,
  output logic [31:0] first_num,
  output logic [31:0] second_num,
  output logic [1:0]  op,
  output logic [31:0] answer,
  output logic        busy,
  output logic        error,
  output logic [2:0]  state
);

  localparam int unsigned DW = 32;
  localparam int unsigned OW = 2;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  function automatic logic [DW-1:0] pow10(input int unsigned n);
    logic [DW-1:0] r;
    r = DW'(1);
    for (int unsigned i = 0; i < n; i++) r = DW'(r * DW'(10));
    return r;
  endfunction

  // An operand at or above this value already holds MAX_DIGITS significant digits.
  localparam logic [DW-1:0] DIGIT_LIMIT = pow10(MAX_DIGITS - 1);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_EXEC = 3'd3,
    S_RES  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t          state_q, state_nxt;
  logic [DW-1:0]   first_nxt, second_nxt, answer_nxt;
  logic [DW-1:0]   alu_a_nxt, alu_b_nxt;
  logic [OW-1:0]   op_nxt, alu_op_nxt, pend_op_q, pend_op_nxt;
  logic            chain_q, chain_nxt;
  logic            alu_start_nxt, busy_nxt, error_nxt;
  logic [CW-1:0]   cnt_q, cnt_nxt;

  logic            key_digit, key_oper, key_eq, key_clr;
  logic [OW-1:0]   key_op;
  logic [DW-1:0]   key_val;

  function automatic logic [DW-1:0] append(input logic [DW-1:0] v, input logic [3:0] d);
    return DW'(v * DW'(10)) + DW'(d);
  endfunction

  // Keypad decode; every class is qualified by key_valid.
  always_comb begin
    key_digit = key_valid && (key_code <= 4'd9);
    key_oper  = key_valid && (key_code inside {[4'hA:4'hD]});
    key_eq    = key_valid && (key_code == 4'hE);
    key_clr   = key_valid && (key_code == 4'hF);
    key_op    = OW'(key_code - 4'hA);
    key_val   = DW'(key_code);
  end

  always_comb begin
    state_nxt     = state_q;
    first_nxt     = first_num;
    second_nxt    = second_num;
    op_nxt        = op;
    answer_nxt    = answer;
    pend_op_nxt   = pend_op_q;
    chain_nxt     = chain_q;
    cnt_nxt       = '0;
    alu_a_nxt     = alu_a;
    alu_b_nxt     = alu_b;
    alu_op_nxt    = alu_op;
    alu_start_nxt = 1'b0;

    case (state_q)
      S_A: begin
        if (key_digit) begin
          if (first_num < DIGIT_LIMIT) first_nxt = append(first_num, key_code);
        end else if (key_oper) begin
          op_nxt    = key_op;
          state_nxt = S_OP;
        end else if (key_eq) begin
          answer_nxt = first_num;
          state_nxt  = S_RES;
        end
      end
      S_OP: begin
        if (key_digit) begin
          second_nxt = key_val;
          state_nxt  = S_B;
        end else if (key_oper) begin
          op_nxt = key_op;
        end
      end
      S_B: begin
        if (key_digit) begin
          if (second_num < DIGIT_LIMIT) second_nxt = append(second_num, key_code);
        end else if (key_oper) begin
          pend_op_nxt = key_op;
          chain_nxt   = 1'b1;
          state_nxt   = S_EXEC;
        end else if (key_eq) begin
          chain_nxt = 1'b0;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        cnt_nxt = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + CW'(1);
        // alu_done takes priority over a coincident timeout and over any key but clear.
        if (alu_done) begin
          if (alu_err) begin
            answer_nxt = '0;
            state_nxt  = S_ERR;
          end else begin
            answer_nxt = alu_result;
            if (chain_q) begin
              first_nxt  = alu_result;
              second_nxt = '0;
              op_nxt     = pend_op_q;
              state_nxt  = S_OP;
            end else begin
              state_nxt = S_RES;
            end
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          answer_nxt = '0;
          state_nxt  = S_ERR;
        end
      end
      S_RES: begin
        if (key_digit) begin
          first_nxt  = key_val;
          second_nxt = '0;
          state_nxt  = S_A;
        end else if (key_oper) begin
          first_nxt = answer;
          op_nxt    = key_op;
          state_nxt = S_OP;
        end
      end
      S_ERR: begin
      end
      default: state_nxt = S_A;
    endcase

    // Clear overrides everything, including a coincident alu_done.
    if (key_clr) begin
      first_nxt   = '0;
      second_nxt  = '0;
      op_nxt      = '0;
      answer_nxt  = '0;
      pend_op_nxt = '0;
      chain_nxt   = 1'b0;
      state_nxt   = S_A;
    end

    // Launch the ALU request on entry; operands stay frozen while executing.
    if (state_nxt == S_EXEC && state_q != S_EXEC) begin
      alu_start_nxt = 1'b1;
      alu_a_nxt     = first_num;
      alu_b_nxt     = second_num;
      alu_op_nxt    = op;
      cnt_nxt       = '0;
    end

    busy_nxt  = (state_nxt == S_EXEC);
    error_nxt = (state_nxt == S_ERR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_A;
      first_num  <= '0;
      second_num <= '0;
      op         <= '0;
      answer     <= '0;
      pend_op_q  <= '0;
      chain_q    <= 1'b0;
      cnt_q      <= '0;
      alu_start  <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      busy       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      first_num  <= first_nxt;
      second_num <= second_nxt;
      op         <= op_nxt;
      answer     <= answer_nxt;
      pend_op_q  <= pend_op_nxt;
      chain_q    <= chain_nxt;
      cnt_q      <= cnt_nxt;
      alu_start  <= alu_start_nxt;
      alu_a      <= alu_a_nxt;
      alu_b      <= alu_b_nxt;
      alu_op     <= alu_op_nxt;
      busy       <= busy_nxt;
      error      <= error_nxt;
    end
  end

  assign state = state_q;

endmodule
